// File: rtl/ac_motor_pkg.sv
// Shared definitions for the AC motor dead-time generator: phase-state
// encoding and default sizing.
package ac_motor_pkg;

  localparam int PHASES_DEF  = 3;
  localparam int DELAY_W_DEF = 11;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_DEAD_H = 3'd1,
    ST_HIGH   = 3'd2,
    ST_DEAD_L = 3'd3,
    ST_LOW    = 3'd4
  } phase_state_e;

endpackage

// File: rtl/ac_motor_deadtime_channel.sv
// One half-bridge channel: dead-time FSM that never lets high and low
// gate drives overlap and always inserts DELAY+1 dead cycles before conduction.
module ac_motor_deadtime_channel
  import ac_motor_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_force_off,
  input  logic               i_s_in,
  input  logic [DELAY_W-1:0] i_delay,
  output logic               o_s_high,
  output logic               o_s_low,
  output logic               o_dead,
  output phase_state_e       o_state
);

  phase_state_e       r_state;
  logic [DELAY_W-1:0] r_cnt;
  logic               r_s_high;
  logic               r_s_low;
  logic               r_dead;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_s_high <= 1'b0;
      r_s_low  <= 1'b0;
      r_dead   <= 1'b0;
    end else if (i_force_off) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_s_high <= 1'b0;
      r_s_low  <= 1'b0;
      r_dead   <= 1'b0;
    end else begin
      case (r_state)
        // OFF has no conducting side, so any request starts a full dead period.
        ST_OFF: begin
          r_state  <= i_s_in ? ST_DEAD_H : ST_DEAD_L;
          r_cnt    <= i_delay;
          r_dead   <= 1'b1;
          r_s_high <= 1'b0;
          r_s_low  <= 1'b0;
        end
        ST_HIGH: begin
          if (!i_s_in) begin
            r_state  <= ST_DEAD_L;
            r_cnt    <= i_delay;
            r_dead   <= 1'b1;
            r_s_high <= 1'b0;
          end
        end
        ST_LOW: begin
          if (i_s_in) begin
            r_state <= ST_DEAD_H;
            r_cnt   <= i_delay;
            r_dead  <= 1'b1;
            r_s_low <= 1'b0;
          end
        end
        // A reversal restarts the dead period toward the new side.
        ST_DEAD_H: begin
          if (!i_s_in) begin
            r_state <= ST_DEAD_L;
            r_cnt   <= i_delay;
          end else if (r_cnt == '0) begin
            r_state  <= ST_HIGH;
            r_s_high <= 1'b1;
            r_dead   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DEAD_L: begin
          if (i_s_in) begin
            r_state <= ST_DEAD_H;
            r_cnt   <= i_delay;
          end else if (r_cnt == '0) begin
            r_state <= ST_LOW;
            r_s_low <= 1'b1;
            r_dead  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_OFF;
          r_cnt    <= '0;
          r_s_high <= 1'b0;
          r_s_low  <= 1'b0;
          r_dead   <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_high = r_s_high;
  assign o_s_low  = r_s_low;
  assign o_dead   = r_dead;
  assign o_state  = r_state;

endmodule

// File: rtl/ac_motor_deadtime_gen.sv
// Multi-phase dead-time generator: owns the fault latch and the enable/fault
// gating, and fans the shared dead time out to one channel per phase.
module ac_motor_deadtime_gen
  import ac_motor_pkg::*;
#(
  parameter int PHASES  = PHASES_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic [DELAY_W-1:0]        DELAY,
  input  logic [PHASES-1:0]         S_IN,
  input  logic                      FAULT,
  input  logic                      FAULT_CLR,
  output logic [PHASES-1:0]         S_HIGH,
  output logic [PHASES-1:0]         S_LOW,
  output logic [PHASES-1:0]         DEAD,
  output logic                      FAULT_ACTIVE,
  output phase_state_e [PHASES-1:0] o_dbg_state
);

  logic r_fault_active;
  logic w_force_off;

  // A live FAULT outranks FAULT_CLR, so a clear only lands once FAULT is low.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fault_active <= 1'b0;
    end else if (FAULT) begin
      r_fault_active <= 1'b1;
    end else if (FAULT_CLR) begin
      r_fault_active <= 1'b0;
    end
  end

  assign w_force_off  = FAULT | r_fault_active | ~ENABLE;
  assign FAULT_ACTIVE = r_fault_active;

  for (genvar g = 0; g < PHASES; g++) begin : g_ch
    ac_motor_deadtime_channel #(
      .DELAY_W(DELAY_W)
    ) u_ch (
      .CLK        (CLK),
      .RESET      (RESET),
      .i_force_off(w_force_off),
      .i_s_in     (S_IN[g]),
      .i_delay    (DELAY),
      .o_s_high   (S_HIGH[g]),
      .o_s_low    (S_LOW[g]),
      .o_dead     (DEAD[g]),
      .o_state    (o_dbg_state[g])
    );
  end

endmodule
